// File: rtl/param_delay_line_if.sv
// Sample/tap bus of the parametrised FIR input delay line.
// master : sample source/controller (drives enables, sample, tap address)
// slave  : the delay line (returns tap read, flat tap bus, fill state, strobe)
interface param_delay_line_if #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned DEPTH  = 33,
  parameter int unsigned ADDR_W = 6
);
  logic                     iEnSample_600k;
  logic                     iEnDelay;
  logic                     iClear;
  logic [DATA_W-1:0]        iFirIn;
  logic [ADDR_W-1:0]        iTapAddr;
  logic [DATA_W-1:0]        oTapData;
  logic [DEPTH*DATA_W-1:0]  oTapAll;
  logic [ADDR_W-1:0]        oFillCnt;
  logic                     oFull;
  logic                     oShiftDone;

  modport master (
    output iEnSample_600k, iEnDelay, iClear, iFirIn, iTapAddr,
    input  oTapData, oTapAll, oFillCnt, oFull, oShiftDone
  );

  modport slave (
    input  iEnSample_600k, iEnDelay, iClear, iFirIn, iTapAddr,
    output oTapData, oTapAll, oFillCnt, oFull, oShiftDone
  );
endinterface

// File: rtl/param_delay_line.sv
// DEPTH-tap shift register of DATA_W-bit two's complement samples feeding a
// direct-form MAC stage. Samples are carried as raw bit patterns, so sign is
// preserved without any arithmetic on the data path.
// Ports:
//   iClk_12M : system clock
//   iRst     : asynchronous active-high reset
//   bus      : slave side of param_delay_line_if
//              (iEnSample_600k, iEnDelay, iClear, iFirIn, iTapAddr in;
//               oTapData, oTapAll, oFillCnt, oFull, oShiftDone out)
module param_delay_line #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned DEPTH  = 33,
  parameter int unsigned ADDR_W = 6
) (
  input  logic            iClk_12M,
  input  logic            iRst,
  param_delay_line_if.slave bus
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  logic [DATA_W-1:0] tap_q [DEPTH];
  logic [DATA_W-1:0] tap_d [DEPTH];
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic              full_q, full_d;
  logic              shift_done_q, shift_done_d;
  logic              shift_c;

  // Clear has priority over the sample enable.
  assign shift_c = bus.iEnDelay & bus.iEnSample_600k & ~bus.iClear;

  // Next-state for chain, fill counter, strobe and tap read.
  always_comb begin
    tap_d        = tap_q;
    fill_d       = fill_q;
    full_d       = full_q;
    shift_done_d = shift_c;
    rd_d         = '0;

    if (bus.iClear) begin
      for (int unsigned k = 0; k < DEPTH; k++) tap_d[k] = '0;
      fill_d = '0;
      full_d = 1'b0;
    end else if (shift_c) begin
      tap_d[0] = bus.iFirIn;
      for (int unsigned k = 1; k < DEPTH; k++) tap_d[k] = tap_q[k-1];
      // Saturate at DEPTH; full tracks the registered count exactly.
      if (fill_q < DEPTH_A) begin
        fill_d = fill_q + ONE_A;
        full_d = ((fill_q + ONE_A) == DEPTH_A);
      end
    end

    // Read mux sees pre-edge register contents; out-of-range addresses give 0.
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (bus.iTapAddr == ADDR_W'(k)) rd_d = tap_q[k];
    end
  end

  // State registers.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      for (int unsigned k = 0; k < DEPTH; k++) tap_q[k] <= '0;
      rd_q         <= '0;
      fill_q       <= '0;
      full_q       <= 1'b0;
      shift_done_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) tap_q[k] <= tap_d[k];
      rd_q         <= rd_d;
      fill_q       <= fill_d;
      full_q       <= full_d;
      shift_done_q <= shift_done_d;
    end
  end

  // Flat tap bus, tap 0 (newest) in the least significant slice.
  for (genvar g = 0; g < DEPTH; g++) begin : g_tap_all
    assign bus.oTapAll[g*DATA_W +: DATA_W] = tap_q[g];
  end

  assign bus.oTapData   = rd_q;
  assign bus.oFillCnt   = fill_q;
  assign bus.oFull      = full_q;
  assign bus.oShiftDone = shift_done_q;

endmodule

// File: doc/param_delay_line.md
Name: param_delay_line

Overview:
Parametrised successor to the fixed 33-tap, 3-bit FIR input delay chain. It provides a DEPTH-tap shift register of DATA_W-bit signed samples, with all taps exported as a flat bus. It adds a registered random-access tap read port, a fill counter with a full flag, a synchronous flush, and a shift-done strobe. It sits between the sample source and the direct-form MAC/accumulator stage, which uses oFull to suppress start-up transients and oShiftDone to start a multiply-accumulate sweep.

Parameters:
DATA_W, 3, sample width in bits (signed two's complement)
DEPTH, 33, number of taps (≥2)
ADDR_W, 6, width of tap address and fill count; must satisfy 2^ADDR_W > DEPTH

Ports:
iClk_12M  input  1  system clock, 12 MHz
iRst  input  1  asynchronous, active-high reset
iEnSample_600k  input  1  sample-rate enable, one-cycle pulse every 20 clocks
iEnDelay  input  1  chain enable from controller
iClear  input  1  synchronous flush of chain and fill count
iFirIn  input  DATA_W  signed input sample
iTapAddr  input  ADDR_W  tap index for random read; 0 = newest sample
oTapData  output  DATA_W  registered read of tap[iTapAddr]
oTapAll  output  DEPTH*DATA_W  all taps flattened; bits [DATA_W-1:0] = tap 0 (newest)
oFillCnt  output  ADDR_W  number of valid samples in chain, saturates at DEPTH
oFull  output  1  high when oFillCnt == DEPTH
oShiftDone  output  1  one-cycle pulse the cycle after a shift occurred

Behaviour:
- Reset (iRst high, asynchronous): all taps = 0, oTapData = 0, oFillCnt = 0, oFull = 0, oShiftDone = 0. Registers hold reset while iRst is high. Normal operation resumes on the first iClk_12M edge after deassertion. Reset mid-stream discards all samples; there is no partial retention.
- Shift condition: shift = iEnDelay & iEnSample_600k & ~iClear.
  - On shift: tap[0] <= iFirIn; tap[k] <= tap[k-1] for k = 1..DEPTH-1. The oldest sample is dropped.
  - Otherwise all taps hold.
- Clear: iClear has priority over shift. On a clock edge with iClear = 1:
  - all taps = 0, oFillCnt = 0, oFull = 0, oShiftDone = 0;
  - the sample presented that cycle is discarded.
- Fill counter: increments by 1 on each shift while < DEPTH, then saturates at DEPTH (no wrap). oFull is registered alongside the counter, so oFull = (oFillCnt == DEPTH) at all times.
- oShiftDone: registered copy of the shift condition. High exactly one cycle after each accepted shift, aligned with the updated taps becoming visible on oTapAll.
- Tap read port:
  - oTapData <= tap[iTapAddr] on every clock edge, independent of enables. Latency is 1 cycle.
  - On a shift edge the read samples the pre-shift tap contents (old register values).
  - iTapAddr ≥ DEPTH returns 0; it is not an error and holds no state.
- oTapAll is driven directly from the tap registers (0-cycle combinational exposure of register outputs).
- No arithmetic. Widths pass through unchanged and sign is preserved.
- Simultaneous iClear and iEnSample_600k: the clear wins and the fill count goes to 0. A sample arriving the next cycle is not captured unless the enable pulses again.
- iEnDelay low: the chain is frozen. The fill count and oShiftDone do not advance. Reads continue to work.
- An iEnSample_600k pulse held longer than one cycle shifts once per cycle it is high. There is no edge detection; the source is responsible for one-cycle pulses.

Test Plan:
1. Reset and idle: assert iRst mid-cycle (asynchronous), release, drive no enables for 50 cycles → oTapAll = 0, oFillCnt = 0, oFull = 0, oShiftDone never high.
2. Fill and full: iEnDelay = 1, feed samples 1,2,3,-4,-3,... on 33 enable pulses → oFillCnt counts 1..33 and stays at 33 on the 34th pulse. oFull rises with count = 33. After 33 pulses, tap 0 = last sample and tap 32 = first sample (1).
3. Random read: after test 2, sweep iTapAddr 0..40 → oTapData matches tap[addr] one cycle later. Addresses 33..40 return 0. A read issued on a shift edge returns the pre-shift value.
4. Clear priority: assert iClear and iEnSample_600k in the same cycle with iFirIn = 3 → all taps 0, oFillCnt = 0, oFull = 0, oShiftDone = 0 next cycle. The next pulse with iFirIn = -2 gives tap 0 = -2 and oFillCnt = 1.
5. Freeze: iEnDelay = 0 during 5 enable pulses → taps, oFillCnt and oShiftDone unchanged. Re-enable → shifting resumes on the next pulse.
6. Parameter sweep: DATA_W = 8, DEPTH = 4, ADDR_W = 3, feed -128, 127, 5, -1, 9 → final taps 9, -1, 5, 127 (newest first) with sign preserved. oFull is high after the 4th sample.
